// File: rtl/mem_ctrl_arb_pkg.sv
// mem_ctrl_arb_pkg
//   Shared types and helpers for the byte-serial memory arbiter. This package
//   holds the FSM state type, the access-size codes, the read-capture pipeline
//   entry, and the byte-count helper. The bus widths match the MemAddrBus and
//   MemBus widths used across the core.
package mem_ctrl_arb_pkg;

  localparam int unsigned MEM_ADDR_BUS_W = 32;
  localparam int unsigned MEM_BUS_W      = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IF_RD,
    ST_MEM_RD,
    ST_MEM_WR,
    ST_DRAIN
  } state_t;

  // Access size codes; 2'b11 is treated as a word everywhere.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // One slot of the read-capture delay line. It records which lane the byte
  // returning RAM_LAT cycles later belongs to, and whether it is the final byte.
  typedef struct packed {
    logic       valid;
    logic       last;
    logic [1:0] lane;
  } cap_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ext_unit.sv
// mem_ext_unit
//   Purely combinational load-data extender. It is shared with the upcoming
//   cache block.
//   raw       : assembled little-endian word (unused upper lanes are don't-care)
//   size      : SZ_B / SZ_H / SZ_W (2'b11 behaves as a word)
//   is_signed : 1 = sign-extend, 0 = zero-extend
//   ext       : extended word; word accesses pass through unchanged
module mem_ext_unit
  import mem_ctrl_arb_pkg::*;
(
  input  logic [MEM_BUS_W-1:0] raw,
  input  logic [1:0]           size,
  input  logic                 is_signed,
  output logic [MEM_BUS_W-1:0] ext
);

  always_comb begin
    ext = raw;
    case (size)
      SZ_B:    ext = {{24{is_signed & raw[7]}},  raw[7:0]};
      SZ_H:    ext = {{16{is_signed & raw[15]}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_ctrl_arb.sv
// mem_ctrl_arb
//   This module arbitrates between the instruction-fetch channel (IF) and the
//   data channel (MEM) for a single byte-wide RAM port. A granted request has
//   its byte addresses issued on consecutive cycles. Read bytes are collected
//   RAM_LAT cycles after issue, and the result is returned with a one-cycle
//   done pulse. MEM requests win ties and are never preempted. An IF read can
//   be cancelled.
//   Ports:
//     clk, rst (async, active low)
//     if_req/if_addr/if_cancel     -> if_rdata/if_done   (4-byte reads only)
//     mem_req/mem_we/mem_size/mem_signed/mem_addr/mem_wdata
//                                  -> mem_rdata/mem_done
//     ram_addr/ram_wr/ram_wdata    -> external RAM, ram_rdata <- RAM
//   DATA_W must be 32. RAM_LAT must be in the range 1..3.
module mem_ctrl_arb
  import mem_ctrl_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = MEM_ADDR_BUS_W,
  parameter int unsigned DATA_W  = MEM_BUS_W,
  parameter int unsigned RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_cancel,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic              mem_signed,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  state_t            state_q;
  logic              own_if_q;   // DRAIN is shared; this records who owns it
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              sgn_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        nbytes_q;
  logic [2:0]        cnt_q;      // next lane to issue
  logic [DATA_W-1:0] asm_q;
  cap_t              cap_q [RAM_LAT];

  cap_t              push;
  cap_t              cap;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] ext_word;
  logic              cancel_now;

  assign cap = cap_q[RAM_LAT-1];

  assign cancel_now = if_cancel &&
                      ((state_q == ST_IF_RD) || (state_q == ST_DRAIN && own_if_q));

  // The capture tag for the read byte issued at this edge (lane 0 on a read grant).
  always_comb begin
    push = '0;
    if (state_q == ST_IDLE) begin
      if (mem_req) begin
        if (!mem_we) begin
          push.valid = 1'b1;
          push.last  = (size_bytes(mem_size) == 3'd1);
        end
      end else if (if_req && !if_cancel) begin
        push.valid = 1'b1;
      end
    end else if ((state_q == ST_IF_RD && !if_cancel) || state_q == ST_MEM_RD) begin
      push.valid = 1'b1;
      push.last  = (cnt_q == nbytes_q - 3'd1);
      push.lane  = cnt_q[1:0];
    end
  end

  // The final byte is merged here so the result can be registered on the
  // same edge that captures it.
  always_comb begin
    merged = asm_q;
    if (cap.valid) merged[{cap.lane, 3'b000} +: 8] = ram_rdata;
  end

  mem_ext_unit u_ext (
    .raw       (merged),
    .size      (size_q),
    .is_signed (sgn_q),
    .ext       (ext_word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      own_if_q  <= 1'b0;
      addr_q    <= '0;
      size_q    <= SZ_B;
      sgn_q     <= 1'b0;
      wdata_q   <= '0;
      nbytes_q  <= '0;
      cnt_q     <= '0;
      asm_q     <= '0;
      for (int unsigned i = 0; i < RAM_LAT; i++) cap_q[i] <= '0;
      if_rdata  <= '0;
      if_done   <= 1'b0;
      mem_rdata <= '0;
      mem_done  <= 1'b0;
      ram_addr  <= '0;
      ram_wr    <= 1'b0;
      ram_wdata <= '0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;

      cap_q[0] <= push;
      for (int unsigned i = 1; i < RAM_LAT; i++) cap_q[i] <= cap_q[i-1];
      if (cap.valid) asm_q <= merged;

      case (state_q)
        ST_IDLE: begin
          if (mem_req) begin
            addr_q   <= mem_addr;
            size_q   <= mem_size;
            sgn_q    <= mem_signed;
            wdata_q  <= mem_wdata;
            nbytes_q <= size_bytes(mem_size);
            cnt_q    <= 3'd1;
            asm_q    <= '0;
            own_if_q <= 1'b0;
            ram_addr <= mem_addr;
            if (mem_we) begin
              ram_wr    <= 1'b1;
              ram_wdata <= mem_wdata[7:0];
              state_q   <= ST_MEM_WR;
            end else begin
              state_q <= (size_bytes(mem_size) == 3'd1) ? ST_DRAIN : ST_MEM_RD;
            end
          end else if (if_req && !if_cancel) begin
            addr_q   <= if_addr;
            size_q   <= SZ_W;
            sgn_q    <= 1'b0;
            nbytes_q <= 3'd4;
            cnt_q    <= 3'd1;
            asm_q    <= '0;
            own_if_q <= 1'b1;
            ram_addr <= if_addr;
            state_q  <= ST_IF_RD;
          end
        end

        ST_IF_RD, ST_MEM_RD: begin
          if (cancel_now) begin
            state_q <= ST_IDLE;
            for (int unsigned i = 0; i < RAM_LAT; i++) cap_q[i] <= '0;
          end else begin
            ram_addr <= addr_q + ADDR_W'(cnt_q);
            cnt_q    <= cnt_q + 3'd1;
            if (cnt_q == nbytes_q - 3'd1) state_q <= ST_DRAIN;
          end
        end

        ST_MEM_WR: begin
          if (cnt_q == nbytes_q) begin
            ram_wr   <= 1'b0;
            mem_done <= 1'b1;
            state_q  <= ST_IDLE;
          end else begin
            ram_addr  <= addr_q + ADDR_W'(cnt_q);
            ram_wdata <= wdata_q[{cnt_q[1:0], 3'b000} +: 8];
            cnt_q     <= cnt_q + 3'd1;
          end
        end

        ST_DRAIN: begin
          if (cancel_now) begin
            state_q <= ST_IDLE;
            for (int unsigned i = 0; i < RAM_LAT; i++) cap_q[i] <= '0;
          end else if (cap.valid && cap.last) begin
            if (own_if_q) begin
              if_done  <= 1'b1;
              if_rdata <= merged;
            end else begin
              mem_done  <= 1'b1;
              mem_rdata <= ext_word;
            end
            state_q <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_ctrl_arb.md
Name: mem_ctrl_arb

Overview:
- Successor of the instruction-only byte-serial memory controller.
- Arbitrates between the instruction-fetch channel (IF, read-only, cancellable) and the data channel (MEM, read/write, 1/2/4 bytes) for a single byte-wide RAM port.
- Pipelines byte addresses back-to-back and assembles or extends read data.
- Sits between the IF/MEM pipeline stages and the external RAM.

Parameters:
- ADDR_W, 32, address width of requests and the RAM port.
- DATA_W, 32, channel data width; must be 32 (four bytes).
- RAM_LAT, 1, cycles from address/wr driven to rdata valid; legal range 1..3.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low; clears all state and outputs immediately.
- if_req  in  1  IF read request, held high until if_done or cancel.
- if_addr  in  ADDR_W  IF fetch address; always a 4-byte read.
- if_cancel  in  1  abort an in-flight or pending IF request.
- if_rdata  out  DATA_W  fetched word, valid when if_done=1.
- if_done  out  1  one-cycle completion pulse.
- mem_req  in  1  MEM request, held until mem_done.
- mem_we  in  1  1 = store, 0 = load.
- mem_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- mem_signed  in  1  loads: 1 sign-extend, 0 zero-extend.
- mem_addr  in  ADDR_W  MEM byte address.
- mem_wdata  in  DATA_W  store data; byte k = bits [8k+7:8k].
- mem_rdata  out  DATA_W  extended load data, valid when mem_done=1.
- mem_done  out  1  one-cycle completion pulse.
- ram_addr  out  ADDR_W  RAM byte address.
- ram_wr  out  1  RAM write strobe.
- ram_wdata  out  8  RAM write byte.
- ram_rdata  in  8  RAM read byte.

Behaviour:
- Reset, asynchronous low: state IDLE, counters 0. All outputs 0: if_rdata, if_done, mem_rdata, mem_done, ram_addr, ram_wr, ram_wdata.
- States: IDLE, IF_RD, MEM_RD, MEM_WR, DRAIN.
- IDLE grant rule: mem_req wins over if_req on the same cycle. The IF request stays pending.
- IF is ignored in IDLE while if_cancel=1.
- Grant edge G: request fields are latched (addr, size, signed, wdata) and N is set to 1/2/4. Held inputs are not re-read after G.
- Issue: at edges G..G+N-1, ram_addr = A+k (k = 0..N-1), wrapping modulo 2^ADDR_W.
  - Reads: ram_wr = 0.
  - Writes: ram_wr = 1 and ram_wdata = byte k.
- Read capture: byte k is sampled from ram_rdata at edge G+k+RAM_LAT into lane k. Unused lanes are cleared.
- After the last issue, reads enter DRAIN until all bytes are captured.
- Read done: the done pulse and rdata are registered at edge G+N-1+RAM_LAT. Return to IDLE at the same edge.
- Write done: ram_wr drops and mem_done pulses at edge G+N. Return to IDLE.
- Extension: byte extends from bit 7, half from bit 15; mem_signed=0 zero-fills. Word loads are unmodified. if_rdata is never extended.
- Done is exactly one cycle. The next grant can happen in the cycle the done pulse is high, provided the requester has dropped req. A requester that keeps req high after done gets a new transaction.
- if_cancel during IF_RD or its DRAIN:
  - Next edge: IDLE, ram_wr = 0, no if_done.
  - Partially assembled data is discarded.
  - RAM data still in flight is ignored.
- if_cancel during a MEM transaction has no effect.
- MEM transactions are never preempted. A pending if_req waits.
- Outputs hold their last value between pulses, except done, which is 0.
- rst asserted mid-transaction aborts immediately. No done pulse is produced and no further ram_wr occurs.

Decomposition:
- Shared package/defines:
  - state encodings;
  - size codes SZ_B/SZ_H/SZ_W;
  - the byte-count function from size;
  - bus-width macros matching the existing MemAddrBus/MemBus.
- One sub-module: mem_ext_unit, combinational. Inputs: raw word, size, signed. Output: extended word. Reused by the future cache block.
- Read capture uses a RAM_LAT-deep shift register of valid + lane index, so capture is independent of the issue counter.

Test Plan:
- IF read, RAM_LAT=1, if_addr=0x100, RAM bytes 0x13,0x05,0x50,0x00.
  - Expect ram_addr 0x100..0x103 on consecutive cycles.
  - Expect if_done at G+4 with if_rdata=0x00500513.
- MEM signed byte load of 0x80 at 0x20, then unsigned.
  - Signed: mem_rdata=0xFFFFFF80, mem_done at G+1.
  - Unsigned: 0x00000080.
- MEM half store, mem_wdata=0xDEADBEEF at 0x3E.
  - Expect ram_wr=1 for exactly 2 cycles: (0x3E,0xEF), (0x3F,0xBE).
  - Expect mem_done at G+2.
- if_req and mem_req rise the same cycle.
  - MEM completes first; IF is granted the cycle after mem_done with mem_req low.
  - if_rdata is correct.
- if_cancel at G+2 of an IF read.
  - Expect IDLE next edge, no if_done, ram_wr never 1.
  - A new IF fetch to 0x200 then completes normally.
- Wrap and reset.
  - Word read at 0xFFFFFFFE: addresses FE, FF, 0x0, 0x1.
  - rst low mid-store: all outputs 0 asynchronously; no done after release.
  - Repeat the first scenario with RAM_LAT=3: if_done at G+6.
